// File: rtl/jtoutrun_gfx_arb.sv
// jtoutrun_gfx_arb
// Shares one 16-bit SDRAM read port among the four 32-bit graphics ROM
// requesters of the Out Run video section (0 char, 1 scroll 1, 2 scroll 2,
// 3 object). Each port keeps a one-entry cache of its last word. Misses are
// served round-robin, and each 32-bit word is fetched as a two-beat burst.
// Optional build macro: JTOUTRUN_ARB_OBJPRIO_EN gives the object port
// priority in every arbitration. Ports 0-2 keep rotating among themselves.
module jtoutrun_gfx_arb #(
    parameter int AW = 20,
    parameter int DW = 32
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cs0,
    input  logic          cs1,
    input  logic          cs2,
    input  logic          cs3,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [AW-1:0] addr3,
    output logic          ok0,
    output logic          ok1,
    output logic          ok2,
    output logic          ok3,
    output logic [DW-1:0] data0,
    output logic [DW-1:0] data1,
    output logic [DW-1:0] data2,
    output logic [DW-1:0] data3,
    output logic          sdram_req,
    output logic [AW:0]   sdram_addr,
    input  logic          sdram_ack,
    input  logic          sdram_dok,
    input  logic [15:0]   sdram_din
);

    typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;

    state_t        r_state;
    state_t        w_stateNext;

    logic [3:0]    r_valid;
    logic [AW-1:0] r_last [4];
    logic [DW-1:0] r_data [4];
    logic [1:0]    r_ptr;
    logic [1:0]    r_gnt;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_buf;

    logic [3:0]    w_cs;
    logic [AW-1:0] w_addr [4];
    logic [3:0]    w_hit;
    logic [3:0]    w_miss;
    logic          w_anyMiss;
    logic [1:0]    w_gntIdx;
    logic [1:0]    w_ptrNext;

    assign w_cs      = {cs3, cs2, cs1, cs0};
    assign w_addr[0] = addr0;
    assign w_addr[1] = addr1;
    assign w_addr[2] = addr2;
    assign w_addr[3] = addr3;

    // Hit/miss per port; ok follows the live address so it drops at once
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_hit[i]  = r_valid[i] && (r_last[i] == w_addr[i]);
            w_miss[i] = w_cs[i] && !w_hit[i];
        end
    end

    assign w_anyMiss = |w_miss;

    assign ok0 = cs0 && w_hit[0];
    assign ok1 = cs1 && w_hit[1];
    assign ok2 = cs2 && w_hit[2];
    assign ok3 = cs3 && w_hit[3];

    assign data0 = r_data[0];
    assign data1 = r_data[1];
    assign data2 = r_data[2];
    assign data3 = r_data[3];

    assign sdram_addr = {r_addr, 1'b0};

`ifdef JTOUTRUN_ARB_OBJPRIO_EN
    logic [2:0] w_sum;

    // Object port wins outright; the others rotate mod 3 from ptr+1
    always_comb begin
        w_gntIdx  = r_ptr;
        w_ptrNext = r_ptr;
        w_sum     = 3'd0;
        if (w_miss[3]) begin
            w_gntIdx = 2'd3;
        end else begin
            for (int k = 3; k >= 1; k--) begin
                w_sum = {1'b0, r_ptr} + 3'(k);
                if (w_sum >= 3'd3) begin
                    w_sum = w_sum - 3'd3;
                end
                if (w_miss[w_sum[1:0]]) begin
                    w_gntIdx = w_sum[1:0];
                end
            end
            w_ptrNext = w_gntIdx;
        end
    end
`else
    logic [1:0] w_cand;

    // Pick the first missing port searching upward from ptr+1, wrapping mod 4
    always_comb begin
        w_gntIdx = r_ptr;
        w_cand   = r_ptr;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (w_miss[w_cand]) begin
                w_gntIdx = w_cand;
            end
        end
        w_ptrNext = w_gntIdx;
    end
`endif

    // State register; reset returns to IDLE at once, even mid-burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: a beat arriving together with ack is taken as beat 0
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:  if (w_anyMiss) w_stateNext = REQ;
            REQ:   if (sdram_ack) w_stateNext = sdram_dok ? BEAT1 : BEAT0;
            BEAT0: if (sdram_dok) w_stateNext = BEAT1;
            BEAT1: if (sdram_dok) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // The request is decoded from state, so reset clears it asynchronously
    always_comb begin
        sdram_req = 1'b0;
        if (r_state == REQ) begin
            sdram_req = 1'b1;
        end
    end

    // Grant latch, low-beat buffer and cache fill on the final beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 4'd0;
            r_ptr   <= 2'd0;
            r_gnt   <= 2'd0;
            r_addr  <= '0;
            r_buf   <= 16'd0;
            for (int i = 0; i < 4; i++) begin
                r_last[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyMiss) begin
                        r_addr <= w_addr[w_gntIdx];
                        r_gnt  <= w_gntIdx;
                        r_ptr  <= w_ptrNext;
                    end
                end
                REQ: begin
                    if (sdram_ack && sdram_dok) begin
                        r_buf <= sdram_din;
                    end
                end
                BEAT0: begin
                    if (sdram_dok) begin
                        r_buf <= sdram_din;
                    end
                end
                BEAT1: begin
                    if (sdram_dok) begin
                        r_data[r_gnt]  <= {sdram_din, r_buf};
                        r_last[r_gnt]  <= r_addr;
                        r_valid[r_gnt] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jtoutrun_gfx_arb.sv
// tb_jtoutrun_gfx_arb
// Directed bench for the Out Run graphics ROM arbiter: single miss, hit/miss
// toggling, round-robin order, address change mid-fetch, object-port
// priority ordering and reset during a burst. Honours JTOUTRUN_ARB_OBJPRIO_EN.
module tb_jtoutrun_gfx_arb;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    cs = 4'd0;
    logic [AW-1:0] curAddr [4];
    logic          ok0, ok1, ok2, ok3;
    logic [31:0]   data0, data1, data2, data3;
    logic          sdram_req;
    logic [AW:0]   sdram_addr;
    logic          sdram_ack = 1'b0;
    logic          sdram_dok = 1'b0;
    logic [15:0]   sdram_din = 16'd0;

    int errCount = 0;
    int checkCount = 0;

    jtoutrun_gfx_arb #(.AW(AW), .DW(32)) dut (
        .rst        (rst),
        .clk        (clk),
        .cs0        (cs[0]),
        .cs1        (cs[1]),
        .cs2        (cs[2]),
        .cs3        (cs[3]),
        .addr0      (curAddr[0]),
        .addr1      (curAddr[1]),
        .addr2      (curAddr[2]),
        .addr3      (curAddr[3]),
        .ok0        (ok0),
        .ok1        (ok1),
        .ok2        (ok2),
        .ok3        (ok3),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .data3      (data3),
        .sdram_req  (sdram_req),
        .sdram_addr (sdram_addr),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_din  (sdram_din)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count one comparison and report it if it disagrees
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Select a port's ok flag by index
    function automatic logic getOk(input int p);
        case (p)
            0: getOk = ok0;
            1: getOk = ok1;
            2: getOk = ok2;
            default: getOk = ok3;
        endcase
    endfunction

    // Select a port's data word by index
    function automatic logic [31:0] getData(input int p);
        case (p)
            0: getData = data0;
            1: getData = data1;
            2: getData = data2;
            default: getData = data3;
        endcase
    endfunction

    // Wait (bounded) for a request and report the beat address it carries
    task automatic waitReq(output logic [AW:0] got);
        int n = 0;
        while (!sdram_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reqSeen", {63'd0, sdram_req}, 64'd1);
        got = sdram_addr;
    endtask

    // Controller accepts after a delay of whole cycles
    task automatic doAck(input int delay);
        repeat (delay) @(negedge clk);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
    endtask

    // Controller returns one 16-bit beat
    task automatic doBeat(input logic [15:0] d);
        sdram_dok = 1'b1;
        sdram_din = d;
        @(negedge clk);
        sdram_dok = 1'b0;
    endtask

    // Drive the directed test sequence
    task automatic applyStimulus();
        logic [AW:0] got;
        int          reqDrop;
        int          reqCount;
        int          order [5];
        int          remissIdx;
        int          p;

        // Reset values
        for (int i = 0; i < 4; i++) curAddr[i] = '0;
        @(negedge clk);
        #1;
        checkOutput("rstReq", {63'd0, sdram_req}, 64'd0);
        checkOutput("rstAddr", {43'd0, sdram_addr}, 64'd0);
        checkOutput("rstData0", {32'd0, data0}, 64'd0);
        cs = 4'b0001;
        curAddr[0] = 20'h00010;
        #1;
        checkOutput("rstOk0", {63'd0, ok0}, 64'd0);

        // Single miss
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("missToReq", {63'd0, sdram_req}, 64'd1);
        checkOutput("reqAddr", {43'd0, sdram_addr}, 64'h20);
        reqDrop = 0;
        repeat (2) begin
            @(negedge clk);
            if (!sdram_req || sdram_addr != 21'h20) reqDrop++;
        end
        checkOutput("reqHeld", 64'(reqDrop), 64'd0);
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        checkOutput("reqLowAfterAck", {63'd0, sdram_req}, 64'd0);
        doBeat(16'hBEEF);
        checkOutput("okBeforeFill", {63'd0, ok0}, 64'd0);
        doBeat(16'hDEAD);
        #1;
        checkOutput("okAfterFill", {63'd0, ok0}, 64'd1);
        checkOutput("data0Fill", {32'd0, data0}, 64'hDEADBEEF);
        reqCount = 0;
        repeat (6) begin
            @(negedge clk);
            if (sdram_req) reqCount++;
        end
        checkOutput("noReqOnHit", 64'(reqCount), 64'd0);

        // Hit/miss toggle
        curAddr[0] = 20'h00011;
        #1;
        checkOutput("okDropSameCycle", {63'd0, ok0}, 64'd0);
        waitReq(got);
        checkOutput("toggleAddr", {43'd0, got}, 64'h22);
        doAck(0);
        doBeat(16'h2222);
        doBeat(16'h1111);
        #1;
        checkOutput("toggleOk", {63'd0, ok0}, 64'd1);
        checkOutput("toggleData", {32'd0, data0}, 64'h11112222);
        curAddr[0] = 20'h00010;
        #1;
        checkOutput("oldAddrEvicted", {63'd0, ok0}, 64'd0);
        waitReq(got);
        checkOutput("refetchAddr", {43'd0, got}, 64'h20);
        doAck(0);
        doBeat(16'hBEEF);
        doBeat(16'hDEAD);

        // Round-robin from reset with all four ports missing
        @(negedge clk);
        rst = 1'b1;
        cs = 4'b1111;
        curAddr[0] = 20'h00100;
        curAddr[1] = 20'h00200;
        curAddr[2] = 20'h00300;
        curAddr[3] = 20'h00400;
`ifdef JTOUTRUN_ARB_OBJPRIO_EN
        order = '{3, 1, 2, 0, 1};
        remissIdx = 1;
`else
        order = '{1, 2, 3, 0, 1};
        remissIdx = 0;
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            p = order[i];
            waitReq(got);
            checkOutput($sformatf("rrAddr%0d", i), {43'd0, got}, {43'd0, curAddr[p], 1'b0});
            doAck(1);
            doBeat(16'h0A00 + 16'(i));
            doBeat(16'h0B00 + 16'(i));
            #1;
            checkOutput($sformatf("rrOk%0d", i), {63'd0, getOk(p)}, 64'd1);
            checkOutput($sformatf("rrData%0d", i), {32'd0, getData(p)}, {32'd0, 16'h0B00 + 16'(i), 16'h0A00 + 16'(i)});
            if (i == remissIdx) begin
                curAddr[1] = 20'h00210;
            end
        end

        // Address change during BEAT0
        curAddr[2] = 20'h00301;
        waitReq(got);
        checkOutput("midAddr", {43'd0, got}, 64'h602);
        doAck(0);
        curAddr[2] = 20'h00302;
        doBeat(16'h1111);
        doBeat(16'h2222);
        #1;
        checkOutput("midOkLow", {63'd0, ok2}, 64'd0);
        checkOutput("midStaleData", {32'd0, data2}, 64'h22221111);
        waitReq(got);
        checkOutput("midRefetch", {43'd0, got}, 64'h604);
        doAck(0);
        doBeat(16'h3333);
        doBeat(16'h4444);
        #1;
        checkOutput("midOkHigh", {63'd0, ok2}, 64'd1);

        // Ports 0 and 3 miss together with ptr at 2
        curAddr[0] = 20'h00130;
        curAddr[3] = 20'h00430;
        waitReq(got);
        checkOutput("prioFirst", {43'd0, got}, 64'h860);
        doAck(0);
        doBeat(16'h5555);
        doBeat(16'h6666);
        #1;
        checkOutput("prioOk3", {63'd0, ok3}, 64'd1);
        waitReq(got);
        checkOutput("prioSecond", {43'd0, got}, 64'h260);
        doAck(0);
        doBeat(16'h7777);
        doBeat(16'h8888);
        #1;
        checkOutput("prioOk0", {63'd0, ok0}, 64'd1);

        // Reset while in BEAT1
        curAddr[0] = 20'h00140;
        waitReq(got);
        checkOutput("rstMidAddr", {43'd0, got}, 64'h280);
        doAck(0);
        doBeat(16'h9999);
        rst = 1'b1;
        #1;
        checkOutput("rstMidReq", {63'd0, sdram_req}, 64'd0);
        checkOutput("rstMidOk", {60'd0, ok3, ok2, ok1, ok0}, 64'd0);
        checkOutput("rstMidData0", {32'd0, data0}, 64'd0);
        cs = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        doBeat(16'hAAAA);
        doBeat(16'hBBBB);
        #1;
        checkOutput("strayData0", {32'd0, data0}, 64'd0);
        checkOutput("strayData3", {32'd0, data3}, 64'd0);
        checkOutput("strayReq", {63'd0, sdram_req}, 64'd0);
    endtask

    initial begin
        applyStimulus();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/jtoutrun_gfx_arb.md
Name: jtoutrun_gfx_arb

Overview:
- Shares one 16-bit SDRAM read port among four 32-bit graphics ROM requesters of the Out Run video section: port 0 char, port 1 scroll 1, port 2 scroll 2, port 3 object.
- Each port keeps a one-entry cache (last address and data) and gets round-robin access on a miss.
- Each 32-bit word is fetched as a two-beat SDRAM burst.
- Sits between the tile/object engines and the SDRAM controller.

Parameters:
- AW, 20: word address width of each requester and of the SDRAM address.
- DW, 32: requester data width. Fixed at 2×16 and not to be overridden.

Ports:
- rst  in  1  reset, asynchronous, active-high
- clk  in  1  clock
- cs0..cs3  in  1 each  port read request
- addr0..addr3  in  AW each  port word address
- ok0..ok3  out  1 each  data valid for the current addr
- data0..data3  out  DW each  cached data
- sdram_req  out  1  fetch request to the SDRAM controller
- sdram_addr  out  AW+1  16-bit beat address: {granted addr, 1'b0}
- sdram_ack  in  1  controller accepted the request
- sdram_dok  in  1  one 16-bit beat valid on sdram_din
- sdram_din  in  16  read data beat

Behaviour:
- Reset values:
  - all okN, dataN and sdram_req are 0; sdram_addr is 0.
  - every cache-valid bit is cleared; the RR pointer points to port 0; FSM is in IDLE.
- Per port: hitN = validN && (lastN == addrN). okN = csN && hitN, combinational on addrN/csN, so it drops in the same cycle the address changes. dataN is a register that changes only on fill.
- missN = csN && !hitN.
- FSM states: IDLE, REQ, BEAT0, BEAT1.
- IDLE:
  - If any missN, grant the first missing port searching from ptr+1 (mod 4) upward.
  - Latch the granted addrN into the fetch address and the port index into gnt.
  - Assert sdram_req on the next clk edge and go to REQ.
  - ptr takes the value gnt.
- REQ:
  - sdram_req is held high and sdram_addr is stable until sdram_ack is sampled high.
  - On ack: sdram_req goes low next cycle; go to BEAT0.
  - sdram_dok in the same cycle as ack is legal and counts as beat 0.
- BEAT0: on sdram_dok, capture sdram_din into data[15:0] of the fill buffer; go to BEAT1.
- BEAT1: on sdram_dok:
  - write {sdram_din, buffer[15:0]} to data[gnt];
  - lastN = latched fetch address; valid[gnt] = 1;
  - go to IDLE.
- Latency:
  - miss in IDLE to sdram_req high: 1 cycle.
  - final beat to okN high: 1 cycle, if addrN is unchanged.
  - IDLE spends at least one cycle between fetches.
- Address change mid-fetch: the fetch completes and fills with the old address, so okN stays low. The port misses again and competes normally in the next arbitration.
- csN dropped mid-fetch: the fetch completes and the cache fills; no abort.
- Two ports with the same address: each has its own cache and is fetched separately; there is no cross-port sharing.
- sdram_dok outside BEAT0/BEAT1/REQ-with-ack is ignored.
- Reset mid-fetch:
  - immediate return to IDLE; sdram_req drops asynchronously; valids are cleared.
  - A controller beat arriving after reset is discarded.
- Fairness: no port waits more than 3 fetch cycles after becoming missing.

Optional Feature:
- Macro JTOUTRUN_ARB_OBJPRIO_EN.
- Defined: port 3 (object) wins any IDLE arbitration where miss3=1, regardless of ptr. Ports 0–2 rotate round-robin among themselves, and a port-3 grant does not move ptr.
- Undefined: pure 4-way round-robin as above.

Test Plan:
- Single miss:
  - Stimulus: cs0=1, addr0=0x00010; controller acks 2 cycles after req and then returns beats 0xBEEF, 0xDEAD.
  - Required: sdram_addr=0x00020; ok0 rises 1 cycle after the second beat; data0=0xDEADBEEF.
  - Then, with addr0 held: no further sdram_req.
- Hit/miss toggle:
  - Stimulus: after the fill above, addr0 changes to 0x00011.
  - Required: ok0 falls in the same cycle; new req with sdram_addr=0x00022.
  - Stimulus: addr0 back to 0x00010 after that fill.
  - Required: ok0=0 (single entry now holds 0x00011); a refetch occurs.
- Round-robin:
  - Stimulus: all four ports miss simultaneously from reset.
  - Required: grant order 1,2,3,0 (ptr=0 at reset, search starts at 1).
  - Stimulus: port 1 misses again during the sequence.
  - Required: port 1 is served only after 2,3,0.
- Address change mid-fetch:
  - Stimulus: addr2 changes during BEAT0.
  - Required: the fill completes with the old address; ok2 stays 0; the next arbitration fetches the new address.
- Reset mid-fetch:
  - Stimulus: rst pulses in BEAT1.
  - Required: sdram_req=0 and all ok=0 immediately; a stray sdram_dok afterwards changes no dataN.
- JTOUTRUN_ARB_OBJPRIO_EN defined:
  - Stimulus: ports 0 and 3 miss together while ptr=2.
  - Required: port 3 is granted first and ptr stays 2; port 0 is granted next.
